// File: rtl/tdm_mux_scanner.sv
// Registered N:1 channel multiplexer with manual select and an auto-scan
// sequencer that time-division-multiplexes enabled channels onto one bus.
module tdm_mux_scanner #(
    parameter int unsigned WIDTH    = 4,
    parameter int unsigned CHANNELS = 8,
    parameter int unsigned SEL_W    = 3,
    parameter int unsigned DWELL    = 2
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      en,
    input  logic                      mode,
    input  logic [SEL_W-1:0]          sel,
    input  logic [CHANNELS-1:0]       ch_mask,
    input  logic [CHANNELS*WIDTH-1:0] d,
    output logic [WIDTH-1:0]          y,
    output logic [SEL_W-1:0]          y_ch,
    output logic                      y_valid,
    output logic                      frame_start
);

    localparam int unsigned DW_W = (DWELL > 1) ? $clog2(DWELL) : 1;

    logic [SEL_W-1:0] ptr, ptr_nxt;
    logic [DW_W-1:0]  dwell_cnt, dwell_cnt_nxt;
    logic             prev_mode, prev_mode_nxt;
    logic [WIDTH-1:0] y_nxt;
    logic [SEL_W-1:0] y_ch_nxt;
    logic             y_valid_nxt, frame_start_nxt;

    logic [WIDTH-1:0] sel_data, ptr_data;
    logic             sel_ok, mask_ptr, mask_any;
    logic [SEL_W-1:0] low_idx, hi_idx, next_idx;
    logic             low_found, hi_found, dwell_last;

    // Channel lookup and single-cycle rotated priority search for the next enabled channel.
    always_comb begin
        sel_data  = '0;
        ptr_data  = '0;
        sel_ok    = 1'b0;
        mask_ptr  = 1'b0;
        low_idx   = '0;
        hi_idx    = '0;
        low_found = 1'b0;
        hi_found  = 1'b0;
        for (int unsigned i = 0; i < CHANNELS; i++) begin
            if (SEL_W'(i) == sel) begin
                sel_data = d[i*WIDTH +: WIDTH];
                sel_ok   = 1'b1;
            end
            if (SEL_W'(i) == ptr) begin
                ptr_data = d[i*WIDTH +: WIDTH];
                mask_ptr = ch_mask[i];
            end
            if (ch_mask[i] && !low_found) begin
                low_idx   = SEL_W'(i);
                low_found = 1'b1;
            end
            if (ch_mask[i] && !hi_found && (SEL_W'(i) > ptr)) begin
                hi_idx   = SEL_W'(i);
                hi_found = 1'b1;
            end
        end
        mask_any   = |ch_mask;
        next_idx   = hi_found ? hi_idx : low_idx;
        dwell_last = (dwell_cnt == DW_W'(DWELL - 1));
    end

    // Next-state and output selection.
    always_comb begin
        ptr_nxt         = ptr;
        dwell_cnt_nxt   = dwell_cnt;
        prev_mode_nxt   = prev_mode;
        y_nxt           = y;
        y_ch_nxt        = y_ch;
        y_valid_nxt     = y_valid;
        frame_start_nxt = 1'b0;

        if (!mode) begin
            y_nxt         = sel_ok ? sel_data : '0;
            y_ch_nxt      = sel;
            y_valid_nxt   = sel_ok;
            ptr_nxt       = '0;
            dwell_cnt_nxt = '0;
            prev_mode_nxt = 1'b0;
        end else if (!mask_any) begin
            // Clearing prev_mode here makes a restored mask restart at the lowest channel.
            y_valid_nxt   = 1'b0;
            ptr_nxt       = '0;
            dwell_cnt_nxt = '0;
            prev_mode_nxt = 1'b0;
        end else if (!prev_mode) begin
            y_valid_nxt   = 1'b0;
            ptr_nxt       = low_idx;
            dwell_cnt_nxt = '0;
            prev_mode_nxt = 1'b1;
        end else if (mask_ptr) begin
            y_nxt           = ptr_data;
            y_ch_nxt        = ptr;
            y_valid_nxt     = 1'b1;
            frame_start_nxt = (ptr == low_idx) && (dwell_cnt == '0);
            if (dwell_last) begin
                ptr_nxt       = next_idx;
                dwell_cnt_nxt = '0;
            end else begin
                dwell_cnt_nxt = dwell_cnt + DW_W'(1);
            end
        end else begin
            y_valid_nxt   = 1'b0;
            ptr_nxt       = next_idx;
            dwell_cnt_nxt = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr         <= '0;
            dwell_cnt   <= '0;
            prev_mode   <= 1'b0;
            y           <= '0;
            y_ch        <= '0;
            y_valid     <= 1'b0;
            frame_start <= 1'b0;
        end else if (en) begin
            ptr         <= ptr_nxt;
            dwell_cnt   <= dwell_cnt_nxt;
            prev_mode   <= prev_mode_nxt;
            y           <= y_nxt;
            y_ch        <= y_ch_nxt;
            y_valid     <= y_valid_nxt;
            frame_start <= frame_start_nxt;
        end
    end

endmodule

// File: tb/tb_tdm_mux_scanner.sv
// Self-checking bench for tdm_mux_scanner: vector table, corner-case sequences
// and randomized traffic against a behavioural model on two parameterisations.
module tb_tdm_mux_scanner;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en, mode;
    logic [2:0]  sel;
    logic [7:0]  mask;
    logic [31:0] d;
    logic [3:0]  y8;
    logic [2:0]  ych8;
    logic        yv8, fs8;

    logic        en5, mode5;
    logic [2:0]  sel5;
    logic [4:0]  mask5;
    logic [19:0] d5;
    logic [3:0]  y5;
    logic [2:0]  ych5;
    logic        yv5, fs5;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    tdm_mux_scanner #(.WIDTH(4), .CHANNELS(8), .SEL_W(3), .DWELL(2)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .sel(sel), .ch_mask(mask),
        .d(d), .y(y8), .y_ch(ych8), .y_valid(yv8), .frame_start(fs8)
    );

    tdm_mux_scanner #(.WIDTH(4), .CHANNELS(5), .SEL_W(3), .DWELL(1)) dut5 (
        .clk(clk), .rst_n(rst_n), .en(en5), .mode(mode5), .sel(sel5), .ch_mask(mask5),
        .d(d5), .y(y5), .y_ch(ych5), .y_valid(yv5), .frame_start(fs5)
    );

    typedef struct {
        bit         en;
        bit         mode;
        logic [2:0] sel;
        logic [7:0] mask;
        logic [3:0] y;
        logic [2:0] ych;
        bit         yv;
        bit         fs;
    } vec_t;

    typedef struct {
        int         ptr;
        int         cnt;
        bit         scanning;
        logic [3:0] y;
        int         ych;
        bit         yv;
        bit         fs;
    } m_t;

    // Behavioural model of one enabled clock edge, written from the channel rules.
    function automatic m_t m_step(m_t s, int nch, int dwl, bit rst, bit en_i, bit mode_i,
                                  int sel_i, logic [7:0] mask_i, logic [31:0] d_i);
        m_t n;
        int lo;
        int nx;
        logic [7:0] m;
        n = s;
        if (!rst) begin
            n = '{0, 0, 1'b0, 4'h0, 0, 1'b0, 1'b0};
            return n;
        end
        if (!en_i) return s;
        m  = mask_i & 8'((1 << nch) - 1);
        lo = 0;
        for (int i = nch - 1; i >= 0; i--) if (((m >> i) & 8'h1) != 0) lo = i;
        nx = s.ptr;
        for (int k = nch; k >= 1; k--) if (((m >> ((s.ptr + k) % nch)) & 8'h1) != 0) nx = (s.ptr + k) % nch;
        n.fs = 1'b0;
        if (!mode_i) begin
            n.y        = (sel_i < nch) ? 4'(d_i >> (4 * sel_i)) : 4'h0;
            n.ych      = sel_i;
            n.yv       = (sel_i < nch);
            n.ptr      = 0;
            n.cnt      = 0;
            n.scanning = 1'b0;
        end else if (m == 8'h0) begin
            n.yv       = 1'b0;
            n.ptr      = 0;
            n.cnt      = 0;
            n.scanning = 1'b0;
        end else if (!s.scanning) begin
            n.yv       = 1'b0;
            n.ptr      = lo;
            n.cnt      = 0;
            n.scanning = 1'b1;
        end else if (((m >> s.ptr) & 8'h1) != 0) begin
            n.y   = 4'(d_i >> (4 * s.ptr));
            n.ych = s.ptr;
            n.yv  = 1'b1;
            n.fs  = (s.ptr == lo) && (s.cnt == 0);
            if (s.cnt == dwl - 1) begin
                n.ptr = nx;
                n.cnt = 0;
            end else begin
                n.cnt = s.cnt + 1;
            end
        end else begin
            n.yv  = 1'b0;
            n.ptr = nx;
            n.cnt = 0;
        end
        return n;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk8(input string nm, input bit cy, input logic [3:0] ey,
                        input logic [2:0] ech, input bit ev, input bit ef);
        tests++;
        if ((cy && y8 !== ey) || ych8 !== ech || yv8 !== ev || fs8 !== ef) begin
            fails++;
            $display("FAIL %s: got y=%0h ch=%0d v=%0b fs=%0b, expected y=%0h ch=%0d v=%0b fs=%0b",
                     nm, y8, ych8, yv8, fs8, ey, ech, ev, ef);
        end
    endtask

    task automatic chk5(input string nm, input logic [3:0] ey, input logic [2:0] ech,
                        input bit ev, input bit ef);
        tests++;
        if (y5 !== ey || ych5 !== ech || yv5 !== ev || fs5 !== ef) begin
            fails++;
            $display("FAIL %s: got y=%0h ch=%0d v=%0b fs=%0b, expected y=%0h ch=%0d v=%0b fs=%0b",
                     nm, y5, ych5, yv5, fs5, ey, ech, ev, ef);
        end
    endtask

    localparam logic [31:0] D_INC  = 32'h8765_4321;
    localparam logic [19:0] D5_INC = 20'h5_4321;

    vec_t vt[10];
    m_t   ms8, ms5;
    int   exp_sp[6];
    bit   exp_fsp[6];

    initial begin
        vt[0] = '{1, 0, 3'd5, 8'h00, 4'h6, 3'd5, 1, 0};
        vt[1] = '{1, 0, 3'd7, 8'h00, 4'h8, 3'd7, 1, 0};
        vt[2] = '{1, 0, 3'd3, 8'h00, 4'h4, 3'd3, 1, 0};
        vt[3] = '{1, 1, 3'd3, 8'hFF, 4'h4, 3'd3, 0, 0};
        vt[4] = '{1, 1, 3'd3, 8'hFF, 4'h1, 3'd0, 1, 1};
        vt[5] = '{1, 1, 3'd3, 8'hFF, 4'h1, 3'd0, 1, 0};
        vt[6] = '{1, 1, 3'd3, 8'hFF, 4'h2, 3'd1, 1, 0};
        vt[7] = '{1, 1, 3'd3, 8'hFF, 4'h2, 3'd1, 1, 0};
        vt[8] = '{1, 0, 3'd0, 8'hFF, 4'h1, 3'd0, 1, 0};
        vt[9] = '{0, 0, 3'd6, 8'hFF, 4'h1, 3'd0, 1, 0};
        exp_sp  = '{2, 2, 7, 7, 2, 2};
        exp_fsp = '{1, 0, 0, 0, 1, 0};

        // Reset wins over en/mode/sel.
        rst_n = 1'b0; en = 1'b1; mode = 1'b0; sel = 3'd5; mask = 8'h00; d = D_INC;
        en5 = 1'b1; mode5 = 1'b0; sel5 = 3'd0; mask5 = 5'h00; d5 = D5_INC;
        tick(); tick();
        chk8("reset8", 1, 4'h0, 3'd0, 0, 0);
        chk5("reset5", 4'h0, 3'd0, 0, 0);
        rst_n = 1'b1;

        for (int i = 0; i < 10; i++) begin
            en = vt[i].en; mode = vt[i].mode; sel = vt[i].sel; mask = vt[i].mask;
            tick();
            chk8($sformatf("vec%0d", i), 1, vt[i].y, vt[i].ych, vt[i].yv, vt[i].fs);
        end
        en = 1'b1;

        // Full 8-channel scan, period 16.
        mode = 1'b0; sel = 3'd0; tick();
        mode = 1'b1; mask = 8'hFF; tick();
        chk8("full_entry", 1, 4'h1, 3'd0, 0, 0);
        for (int c = 0; c <= 16; c++) begin
            tick();
            chk8($sformatf("full_c%0d", c), 1, 4'(((c / 2) % 8) + 1), 3'((c / 2) % 8), 1, (c % 16) == 0);
        end

        // Sparse mask with wrap and live data tracking on channel 7.
        mode = 1'b0; tick();
        mode = 1'b1; mask = 8'h84; tick();
        chk8("sparse_entry", 0, 4'h0, 3'd0, 0, 0);
        for (int c = 0; c < 6; c++) begin
            if (c == 3) d[31:28] = 4'h5;
            if (c == 4) d = D_INC;
            tick();
            chk8($sformatf("sparse_c%0d", c), 1,
                 (c == 3) ? 4'h5 : 4'(exp_sp[c] + 1), 3'(exp_sp[c]), 1, exp_fsp[c]);
        end

        // Mask change mid-dwell, all-zero mask, then restore.
        mode = 1'b0; tick();
        mode = 1'b1; mask = 8'h84; tick();
        tick(); chk8("mc_first2", 1, 4'h3, 3'd2, 1, 1);
        mask = 8'h80; tick(); chk8("mc_drop2", 1, 4'h3, 3'd2, 0, 0);
        tick(); chk8("mc_ch7a", 1, 4'h8, 3'd7, 1, 1);
        tick(); chk8("mc_ch7b", 1, 4'h8, 3'd7, 1, 0);
        mask = 8'h00; tick(); chk8("mc_zero", 1, 4'h8, 3'd7, 0, 0);
        tick(); chk8("mc_zero2", 1, 4'h8, 3'd7, 0, 0);
        mask = 8'h84; tick(); chk8("mc_restore_entry", 1, 4'h8, 3'd7, 0, 0);
        tick(); chk8("mc_restart", 1, 4'h3, 3'd2, 1, 1);

        // Enable freeze in mid-dwell, with frame_start high.
        mode = 1'b0; tick();
        mode = 1'b1; mask = 8'hFF; tick();
        tick(); chk8("frz_pre", 1, 4'h1, 3'd0, 1, 1);
        en = 1'b0; d[3:0] = 4'hF;
        for (int c = 0; c < 5; c++) begin
            tick(); chk8($sformatf("frz_hold%0d", c), 1, 4'h1, 3'd0, 1, 1);
        end
        en = 1'b1; d = D_INC;
        tick(); chk8("frz_resume0", 1, 4'h1, 3'd0, 1, 0);
        tick(); chk8("frz_resume1", 1, 4'h2, 3'd1, 1, 0);

        // Five channels, DWELL=1.
        mode5 = 1'b0; sel5 = 3'd0; tick();
        mode5 = 1'b1; mask5 = 5'h1F; tick();
        chk5("p5_entry", 4'h1, 3'd0, 0, 0);
        for (int c = 0; c < 6; c++) begin
            tick(); chk5($sformatf("p5_c%0d", c), 4'((c % 5) + 1), 3'(c % 5), 1, (c % 5) == 0);
        end
        mode5 = 1'b0; sel5 = 3'd6; tick();
        chk5("p5_sel_oob", 4'h0, 3'd6, 0, 0);

        // Randomized traffic against the model.
        rst_n = 1'b0; tick(); rst_n = 1'b1;
        ms8 = '{0, 0, 1'b0, 4'h0, 0, 1'b0, 1'b0};
        ms5 = ms8;
        for (int c = 0; c < 600; c++) begin
            rst_n = ($urandom_range(99) != 0);
            en    = ($urandom_range(9) != 0);
            en5   = ($urandom_range(9) != 0);
            if ($urandom_range(19) == 0) mode = ~mode;
            if ($urandom_range(19) == 0) mode5 = ~mode5;
            sel  = 3'($urandom);
            sel5 = 3'($urandom);
            if ($urandom_range(7) == 0) mask = ($urandom_range(3) == 0) ? 8'h00 : 8'($urandom);
            if ($urandom_range(7) == 0) mask5 = ($urandom_range(3) == 0) ? 5'h00 : 5'($urandom);
            d  = $urandom;
            d5 = 20'($urandom);
            ms8 = m_step(ms8, 8, 2, rst_n, en, mode, int'(sel), mask, d);
            ms5 = m_step(ms5, 5, 1, rst_n, en5, mode5, int'(sel5), {3'b000, mask5}, {12'h000, d5});
            tick();
            chk8($sformatf("rnd8_%0d", c), 1, ms8.y, 3'(ms8.ych), ms8.yv, ms8.fs);
            chk5($sformatf("rnd5_%0d", c), ms5.y, 3'(ms5.ych), ms5.yv, ms5.fs);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
